time_nmr_replicate_start: RTL and testbench
===========================================

Name: time_nmr_replicate_start

Overview:
- Ingress stage of the time-redundant lock datapath.
- Accepts one upstream transaction per valid/ready handshake and re-issues it downstream 1, 2 or 3 times (bypass/DMR/TMR, runtime-selectable).
- Every copy carries the same transaction ID, plus a replica index and a last-copy flag, so the downstream voter/lock stage can regroup copies per opgroup.
- Generalises the fixed-TMR start stage: runtime mode, parametrised opgroup count, ID width and data type.

Parameters:
- DataType, logic [7:0], payload type carried unchanged.
- NumOpgroups, 3, number of operation groups.
- OpgroupWidth, $clog2(NumOpgroups), width of the opgroup tag.
- IDSize, 4, transaction ID width; IDs wrap modulo 2^IDSize.
- MaxRedundancy, 3, maximum copies per transaction; legal values 1..3.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-high (state cleared while rst_n=1).
- mode_i  in  2  0=bypass (1 copy), 1=DMR (2 copies), 2=TMR (3 copies), 3=reserved (treated as TMR); clamped to MaxRedundancy.
- opgroup_i  in  OpgroupWidth  opgroup of the incoming transaction.
- data_i  in  DataType  payload.
- valid_i  in  1  upstream valid.
- ready_o  out  1  upstream ready.
- opgroup_o  out  OpgroupWidth  registered opgroup.
- data_o  out  DataType  registered payload.
- id_o  out  IDSize  transaction ID, identical for all copies of one transaction.
- replica_o  out  2  copy index, 0..copies-1.
- last_o  out  1  high on the final copy of a transaction.
- valid_o  out  1  downstream valid.
- ready_i  in  1  downstream ready.
- busy_o  out  1  high while a transaction has copies still pending.

Behaviour:
- Reset (rst_n=1): state=IDLE; valid_o=0, busy_o=0, ready_o=1, id counter=0, replica_o=0, last_o=0; data_o/opgroup_o/id_o=0. Reset asserted mid-transaction discards all pending copies. No partial copy is emitted after reset deasserts.
- FSM states:
  - IDLE: ready_o=1, valid_o=0.
  - ISSUE: valid_o=1; data_o, opgroup_o, id_o held constant; replica_o counts copies.
- Accept: valid_i&&ready_o on a rising edge latches data_i, opgroup_i and the current ID, and samples mode_i into copies_q (1..3).
  - Sets replica_q=0 and state=ISSUE.
  - Latency: first copy is visible on the outputs the cycle after acceptance.
- Mode changes are ignored after sampling. The current transaction always finishes with copies_q copies.
- In ISSUE, each valid_o&&ready_i advances replica_q. last_o = (replica_q == copies_q-1).
- On the handshake of the last copy:
  - ID counter increments (wraps from 2^IDSize-1 to 0).
  - If valid_i is also high in that cycle, the new transaction is accepted in the same cycle (ready_o = last_o&&ready_i). State stays ISSUE with replica_q=0 and the new payload, so throughput is 1 transaction per copies_q cycles.
  - Otherwise state returns to IDLE.
- ready_o = IDLE || (ISSUE && last_o && ready_i). ready_o may depend combinationally on ready_i; no other output depends combinationally on any input.
- Backpressure: while ready_i=0, every output stays stable and valid_o stays high; valid_o is never retracted before its handshake.
- Bypass mode: each copy has replica_o=0 and last_o=1, giving pass-through with 1-cycle latency.
- busy_o = (state==ISSUE).
- Upstream data changing while ready_o=0 has no effect.

Decomposition:
- Shared package time_nmr_pkg holds:
  - mode enum (MODE_BYPASS, MODE_DMR, MODE_TMR);
  - function copies_for_mode(mode, MaxRedundancy) returning 1..3;
  - the replica index width constant (2).
- Natural sub-module: time_nmr_id_counter. A wrapping IDSize counter with an increment enable, reused later by the matching end/voter stage.

Test Plan:
- TMR, ready_i=1, send data 0xA5 opgroup 1 -> three copies on consecutive cycles starting 1 cycle after accept; id_o=0, replica_o=0,1,2; last_o only on copy 2.
- DMR back-to-back: 0x11 then 0x22 held valid -> copies 0x11(id0,r0), 0x11(id0,r1,last), 0x22(id1,r0), 0x22(id1,r1,last), with no bubble; ready_o high exactly on the last-copy cycles.
- Backpressure: TMR 0x3C with ready_i toggled 0,0,1,0,1,1 -> outputs stable while stalled; exactly 3 handshakes; valid_o never drops early.
- ID wrap, IDSize=4: 17 bypass transactions -> id_o sequence 0..15 then 0.
- Mode change mid-transaction: accept 0x77 in TMR, switch mode_i to bypass after copy 0 -> 3 copies still issued; next transaction issues 1 copy.
- Reset mid-transaction: assert rst_n for 1 cycle after copy 1 of a TMR transaction -> valid_o=0 and ready_o=1 immediately; next transaction gets id 0, replica 0.

Source files
------------

// File: rtl/time_nmr_pkg.sv
// Shared definitions for the time-redundant (NMR) lock datapath stages.
package time_nmr_pkg;

    localparam int unsigned ReplicaWidth = 2;

    typedef enum logic [1:0] {
        MODE_BYPASS = 2'd0,
        MODE_DMR    = 2'd1,
        MODE_TMR    = 2'd2
    } mode_e;

    // Reserved mode 3 falls through to TMR; result is clamped to the build-time maximum.
    function automatic logic [ReplicaWidth-1:0] copies_for_mode(
        input logic [1:0]  mode,
        input int unsigned max_redundancy
    );
        logic [ReplicaWidth-1:0] copies;
        case (mode)
            MODE_BYPASS: copies = 2'd1;
            MODE_DMR:    copies = 2'd2;
            default:     copies = 2'd3;
        endcase
        if (max_redundancy < 32'(copies)) begin
            copies = ReplicaWidth'(max_redundancy);
        end
        return copies;
    endfunction

endpackage

// File: rtl/time_nmr_id_counter.sv
// Wrapping transaction ID counter shared by the NMR start and end stages.
module time_nmr_id_counter #(
    parameter int unsigned Width = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc_i,
    output logic [Width-1:0] count_o
);

    logic [Width-1:0] count_q;

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            count_q <= '0;
        end else if (inc_i) begin
            count_q <= count_q + Width'(1);
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/time_nmr_replicate_start.sv
// Ingress stage of the time-redundant datapath: re-issues each accepted transaction
// 1..3 times with a shared ID, a replica index and a last-copy flag.
module time_nmr_replicate_start
    import time_nmr_pkg::*;
#(
    parameter type         DataType      = logic [7:0],
    parameter int unsigned NumOpgroups   = 3,
    parameter int unsigned OpgroupWidth  = $clog2(NumOpgroups),
    parameter int unsigned IDSize        = 4,
    parameter int unsigned MaxRedundancy = 3
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [1:0]              mode_i,
    input  logic [OpgroupWidth-1:0] opgroup_i,
    input  DataType                 data_i,
    input  logic                    valid_i,
    output logic                    ready_o,
    output logic [OpgroupWidth-1:0] opgroup_o,
    output DataType                 data_o,
    output logic [IDSize-1:0]       id_o,
    output logic [ReplicaWidth-1:0] replica_o,
    output logic                    last_o,
    output logic                    valid_o,
    input  logic                    ready_i,
    output logic                    busy_o
);

    typedef enum logic {StIdle, StIssue} state_e;

    state_e                  state_q;
    DataType                 data_q;
    logic [OpgroupWidth-1:0] opgroup_q;
    logic [ReplicaWidth-1:0] copies_q;
    logic [ReplicaWidth-1:0] replica_q;
    logic                    last_q;
    logic [ReplicaWidth-1:0] new_copies;
    logic                    accept;
    logic                    handshake;

    assign new_copies = copies_for_mode(mode_i, MaxRedundancy);
    assign valid_o    = (state_q == StIssue);
    assign busy_o     = (state_q == StIssue);
    // A new transaction may enter on the same edge the final copy leaves.
    assign ready_o    = (state_q == StIdle) || (last_q && ready_i);
    assign accept     = valid_i && ready_o;
    assign handshake  = valid_o && ready_i;

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_q   <= StIdle;
            data_q    <= '0;
            opgroup_q <= '0;
            copies_q  <= 2'd1;
            replica_q <= '0;
            last_q    <= 1'b0;
        end else if (accept) begin
            state_q   <= StIssue;
            data_q    <= data_i;
            opgroup_q <= opgroup_i;
            copies_q  <= new_copies;
            replica_q <= '0;
            last_q    <= (new_copies == 2'd1);
        end else if (handshake) begin
            if (last_q) begin
                state_q   <= StIdle;
                replica_q <= '0;
                last_q    <= 1'b0;
            end else begin
                replica_q <= replica_q + 2'd1;
                last_q    <= ((replica_q + 2'd1) == (copies_q - 2'd1));
            end
        end
    end

    // The counter only advances once the final copy is taken, so it doubles as id_o.
    time_nmr_id_counter #(
        .Width (IDSize)
    ) u_id_counter (
        .clk     (clk),
        .rst_n   (rst_n),
        .inc_i   (handshake && last_q),
        .count_o (id_o)
    );

    assign data_o    = data_q;
    assign opgroup_o = opgroup_q;
    assign replica_o = replica_q;
    assign last_o    = last_q;

endmodule

// File: tb/tb_time_nmr_replicate_start.sv
// Scoreboard bench for time_nmr_replicate_start: expected copies are queued on accept.
module tb_time_nmr_replicate_start;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [1:0] mode_i = 2'd0;
    logic [1:0] opgroup_i = 2'd0;
    logic [7:0] data_i = 8'd0;
    logic       valid_i = 1'b0;
    logic       ready_i = 1'b1;
    logic       ready_o;
    logic [1:0] opgroup_o;
    logic [7:0] data_o;
    logic [3:0] id_o;
    logic [1:0] replica_o;
    logic       last_o;
    logic       valid_o;
    logic       busy_o;

    // {data[16:9], opgroup[8:7], id[6:3], replica[2:1], last[0]}
    typedef logic [16:0] vec_t;

    vec_t       sb[$];
    logic [3:0] exp_id = 4'd0;
    int         n_vec = 0;
    int         n_miss = 0;

    always #5 clk = ~clk;

    time_nmr_replicate_start dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mode_i    (mode_i),
        .opgroup_i (opgroup_i),
        .data_i    (data_i),
        .valid_i   (valid_i),
        .ready_o   (ready_o),
        .opgroup_o (opgroup_o),
        .data_o    (data_o),
        .id_o      (id_o),
        .replica_o (replica_o),
        .last_o    (last_o),
        .valid_o   (valid_o),
        .ready_i   (ready_i),
        .busy_o    (busy_o)
    );

    function automatic int exp_copies(input logic [1:0] m);
        if (m == 2'd0) return 1;
        if (m == 2'd1) return 2;
        return 3;
    endfunction

    // One clock: drive inputs, report whether a downstream handshake is pending and
    // queue the expected copies when the bench sees its transaction accepted.
    task automatic cycle(input logic v, input logic [7:0] d, input logic [1:0] og,
                         input logic [1:0] m, input logic rdy,
                         output logic hs, output vec_t obs);
        @(negedge clk);
        valid_i   = v;
        data_i    = d;
        opgroup_i = og;
        mode_i    = m;
        ready_i   = rdy;
        #1;
        hs  = valid_o && ready_i;
        obs = {data_o, opgroup_o, id_o, replica_o, last_o};
        if (valid_i && ready_o) begin
            int n = exp_copies(m);
            for (int r = 0; r < n; r++) begin
                logic [1:0] rr = 2'(r);
                sb.push_back({d, og, exp_id, rr, (r == n - 1)});
            end
            exp_id = exp_id + 4'd1;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n   = 1'b1;
        valid_i = 1'b0;
        ready_i = 1'b1;
        @(negedge clk);
        rst_n = 1'b0;
        sb.delete();
        exp_id = 4'd0;
    endtask

    task automatic test_reset();
        vec_t obs;
        @(negedge clk);
        @(negedge clk);
        obs = {data_o, opgroup_o, id_o, replica_o, last_o};
        n_vec++;
        if (valid_o !== 1'b0) begin n_miss++; $display("FAIL reset_valid: got %b want 0", valid_o); end
        n_vec++;
        if (ready_o !== 1'b1) begin n_miss++; $display("FAIL reset_ready: got %b want 1", ready_o); end
        n_vec++;
        if (busy_o !== 1'b0) begin n_miss++; $display("FAIL reset_busy: got %b want 0", busy_o); end
        n_vec++;
        if (obs !== 17'h0) begin n_miss++; $display("FAIL reset_outputs: got %h want 0", obs); end
        @(negedge clk);
        rst_n = 1'b0;
        sb.delete();
        exp_id = 4'd0;
    endtask

    task automatic test_tmr();
        logic hs;
        vec_t obs, exp_v;
        do_reset();
        cycle(1'b1, 8'hA5, 2'd1, 2'd2, 1'b1, hs, obs);
        n_vec++;
        if (hs !== 1'b0) begin n_miss++; $display("FAIL tmr_accept_cycle: got hs=%b want 0", hs); end
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, 8'h00, 2'd0, 2'd2, 1'b1, hs, obs);
            n_vec++;
            if (hs !== (i < 3)) begin
                n_miss++; $display("FAIL tmr_timing[%0d]: got hs=%b want %b", i, hs, i < 3);
            end
            if (hs) begin
                n_vec++;
                if (sb.size() == 0) begin n_miss++; $display("FAIL tmr_copy: got %h want none", obs); end
                else begin
                    exp_v = sb.pop_front();
                    if (obs !== exp_v) begin n_miss++; $display("FAIL tmr_copy: got %h want %h", obs, exp_v); end
                end
            end
        end
        n_vec++;
        if (sb.size() != 0) begin n_miss++; $display("FAIL tmr_drain: got %0d left want 0", sb.size()); end
    endtask

    task automatic test_back_to_back();
        logic hs;
        vec_t obs, exp_v;
        logic       v_t   [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        logic [7:0] d_t   [5] = '{8'h11, 8'h22, 8'h22, 8'h00, 8'h00};
        logic       hs_t  [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        logic       rdy_t [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        do_reset();
        for (int i = 0; i < 5; i++) begin
            cycle(v_t[i], d_t[i], 2'd2, 2'd1, 1'b1, hs, obs);
            n_vec++;
            if (hs !== hs_t[i]) begin n_miss++; $display("FAIL b2b_hs[%0d]: got %b want %b", i, hs, hs_t[i]); end
            n_vec++;
            if (ready_o !== rdy_t[i]) begin
                n_miss++; $display("FAIL b2b_ready[%0d]: got %b want %b", i, ready_o, rdy_t[i]);
            end
            if (hs) begin
                n_vec++;
                if (sb.size() == 0) begin n_miss++; $display("FAIL b2b_copy: got %h want none", obs); end
                else begin
                    exp_v = sb.pop_front();
                    if (obs !== exp_v) begin n_miss++; $display("FAIL b2b_copy: got %h want %h", obs, exp_v); end
                end
            end
        end
        cycle(1'b0, 8'h00, 2'd0, 2'd1, 1'b1, hs, obs);
        n_vec++;
        if (hs !== 1'b0 || sb.size() != 0) begin
            n_miss++; $display("FAIL b2b_drain: got hs=%b left=%0d want 0/0", hs, sb.size());
        end
    endtask

    task automatic test_backpressure();
        logic hs;
        vec_t obs, exp_v, prev;
        logic prev_hs;
        int   n_hs;
        logic rdy_t [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        do_reset();
        cycle(1'b1, 8'h3C, 2'd0, 2'd2, 1'b1, hs, obs);
        n_hs = 0;
        prev = obs;
        prev_hs = 1'b1;
        for (int i = 0; i < 6; i++) begin
            cycle(1'b0, 8'hFF, 2'd3, 2'd0, rdy_t[i], hs, obs);
            n_vec++;
            if (valid_o !== 1'b1) begin n_miss++; $display("FAIL bp_valid[%0d]: got %b want 1", i, valid_o); end
            if (!prev_hs) begin
                n_vec++;
                if (obs !== prev) begin n_miss++; $display("FAIL bp_stable[%0d]: got %h want %h", i, obs, prev); end
            end
            if (hs) begin
                n_hs++;
                n_vec++;
                if (sb.size() == 0) begin n_miss++; $display("FAIL bp_copy: got %h want none", obs); end
                else begin
                    exp_v = sb.pop_front();
                    if (obs !== exp_v) begin n_miss++; $display("FAIL bp_copy: got %h want %h", obs, exp_v); end
                end
            end
            prev = obs;
            prev_hs = hs;
        end
        n_vec++;
        if (n_hs != 3) begin n_miss++; $display("FAIL bp_count: got %0d want 3", n_hs); end
        cycle(1'b0, 8'h00, 2'd0, 2'd0, 1'b1, hs, obs);
        n_vec++;
        if (valid_o !== 1'b0) begin n_miss++; $display("FAIL bp_idle: got %b want 0", valid_o); end
    endtask

    task automatic test_id_wrap();
        logic hs;
        vec_t obs, exp_v;
        do_reset();
        for (int i = 0; i < 18; i++) begin
            cycle(i < 17, 8'(i), 2'd1, 2'd0, 1'b1, hs, obs);
            if (i > 0) begin
                n_vec++;
                if (!hs) begin n_miss++; $display("FAIL wrap_hs[%0d]: got 0 want 1", i); end
                else if (sb.size() == 0) begin n_miss++; $display("FAIL wrap_copy: got %h want none", obs); end
                else begin
                    exp_v = sb.pop_front();
                    if (obs !== exp_v) begin n_miss++; $display("FAIL wrap_copy[%0d]: got %h want %h", i, obs, exp_v); end
                end
            end
            if (i == 16 || i == 17) begin
                n_vec++;
                if (id_o !== ((i == 16) ? 4'd15 : 4'd0)) begin
                    n_miss++; $display("FAIL wrap_id[%0d]: got %0d want %0d", i, id_o, (i == 16) ? 15 : 0);
                end
            end
        end
    endtask

    task automatic test_mode_change();
        logic hs;
        vec_t obs, exp_v;
        int   n_hs;
        do_reset();
        cycle(1'b1, 8'h77, 2'd2, 2'd2, 1'b1, hs, obs);
        n_hs = 0;
        for (int i = 0; i < 6; i++) begin
            // Mode drops to bypass after copy 0; a second transaction follows once idle.
            if (i == 3)
                cycle(1'b1, 8'h78, 2'd1, 2'd0, 1'b1, hs, obs);
            else
                cycle(1'b0, 8'h00, 2'd0, (i == 0) ? 2'd2 : 2'd0, 1'b1, hs, obs);
            if (hs) begin
                n_hs++;
                n_vec++;
                if (sb.size() == 0) begin n_miss++; $display("FAIL mode_copy: got %h want none", obs); end
                else begin
                    exp_v = sb.pop_front();
                    if (obs !== exp_v) begin n_miss++; $display("FAIL mode_copy[%0d]: got %h want %h", i, obs, exp_v); end
                end
            end
            if (i == 2) begin
                n_vec++;
                if (n_hs != 3) begin n_miss++; $display("FAIL mode_count: got %0d want 3", n_hs); end
            end
        end
        n_vec++;
        if (n_hs != 4 || busy_o !== 1'b0) begin
            n_miss++; $display("FAIL mode_next: got %0d copies busy=%b want 4/0", n_hs, busy_o);
        end
    endtask

    task automatic test_reset_mid();
        logic hs;
        vec_t obs, exp_v;
        do_reset();
        cycle(1'b1, 8'h5A, 2'd2, 2'd2, 1'b1, hs, obs);
        for (int i = 0; i < 2; i++) begin
            cycle(1'b0, 8'h00, 2'd0, 2'd2, 1'b1, hs, obs);
            n_vec++;
            if (!hs) begin n_miss++; $display("FAIL rmid_pre[%0d]: got hs=0 want 1", i); end
            else begin
                exp_v = sb.pop_front();
                if (obs !== exp_v) begin n_miss++; $display("FAIL rmid_pre[%0d]: got %h want %h", i, obs, exp_v); end
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_vec++;
        if (valid_o !== 1'b0 || ready_o !== 1'b1 || busy_o !== 1'b0) begin
            n_miss++; $display("FAIL rmid_async: got v=%b r=%b b=%b want 0/1/0", valid_o, ready_o, busy_o);
        end
        sb.delete();
        exp_id = 4'd0;
        @(negedge clk);
        rst_n = 1'b0;
        cycle(1'b0, 8'h00, 2'd0, 2'd0, 1'b1, hs, obs);
        n_vec++;
        if (hs !== 1'b0) begin n_miss++; $display("FAIL rmid_partial: got hs=%b want 0", hs); end
        cycle(1'b1, 8'h66, 2'd1, 2'd0, 1'b1, hs, obs);
        cycle(1'b0, 8'h00, 2'd0, 2'd0, 1'b1, hs, obs);
        n_vec++;
        if (!hs) begin n_miss++; $display("FAIL rmid_next: got hs=0 want 1"); end
        else begin
            exp_v = sb.pop_front();
            if (obs !== exp_v) begin n_miss++; $display("FAIL rmid_next: got %h want %h", obs, exp_v); end
        end
    endtask

    initial begin
        test_reset();
        test_tmr();
        test_back_to_back();
        test_backpressure();
        test_id_wrap();
        test_mode_change();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
